// File: rtl/npc_unit.sv
// Next-PC selection for a single-delay-slot MIPS-style fetch stage.
// Tracks delay slots, exception and eret redirects, and branches placed in delay slots.
`timescale 1ns/1ps
module npc_unit (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PC,
    input  logic        Stall,
    input  logic        BrTaken,
    input  logic [15:0] Imm16,
    input  logic        JEn,
    input  logic [25:0] Instr26,
    input  logic        JrEn,
    input  logic [31:0] JrAddr,
    input  logic        Exc,
    input  logic        Eret,
    input  logic [31:0] EPC,
    output logic [31:0] NPC,
    output logic [31:0] PC8,
    output logic        InSlot,
    output logic        BadSlot
);

    localparam int unsigned AW = 32;
    localparam logic [AW-1:0] EXC_VECTOR = 32'h0000_4180;

    typedef enum logic {
        SEQ  = 1'b0,
        SLOT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   target_q, target_d;
    logic            bad_q, bad_d;

    logic [AW-1:0]   pc4;
    logic [AW-1:0]   br_target;
    logic [AW-1:0]   j_target;
    logic [AW-1:0]   redirect_target;
    logic            redirect;

    // Candidate targets; all arithmetic wraps at 32 bits.
    always_comb begin
        pc4       = PC + AW'(4);
        br_target = pc4 + {{14{Imm16[15]}}, Imm16, 2'b00};
        j_target  = {pc4[31:28], Instr26, 2'b00};
        redirect  = JrEn | JEn | BrTaken;
        if (JrEn) begin
            redirect_target = JrAddr;
        end else if (JEn) begin
            redirect_target = j_target;
        end else begin
            redirect_target = br_target;
        end
    end

    // Per-cycle priority: Exc > Eret > Stall > slot resolution > new redirect > sequential.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        bad_d    = bad_q;
        NPC      = pc4;
        if (Exc) begin
            NPC      = EXC_VECTOR;
            state_d  = SEQ;
            target_d = '0;
        end else if (Eret) begin
            NPC      = EPC;
            state_d  = SEQ;
            target_d = '0;
        end else if (Stall) begin
            NPC = PC;
        end else if (state_q == SLOT) begin
            NPC     = target_q;
            state_d = SEQ;
            if (redirect) begin
                bad_d = 1'b1;
            end
        end else if (redirect) begin
            target_d = redirect_target;
            state_d  = SLOT;
        end
    end

    always_comb begin
        PC8    = PC + AW'(8);
        InSlot = (state_q == SLOT);
    end

    assign BadSlot = bad_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= SEQ;
            target_q <= '0;
            bad_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            bad_q    <= bad_d;
        end
    end

endmodule

// File: doc/npc_unit.md
NPC_UNIT -- requirements
Module: npc_unit

Interface
REQ-001 SHALL have port Clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port PC, input, 32, current fetch address held by the PC register.
REQ-004 SHALL have port Stall, input, 1, hold fetch this cycle.
REQ-005 SHALL have port BrTaken, input, 1, conditional branch at PC resolved taken.
REQ-006 SHALL have port Imm16, input, 16, branch offset field.
REQ-007 SHALL have port JEn, input, 1, j/jal at PC.
REQ-008 SHALL have port Instr26, input, 26, jump index field.
REQ-009 SHALL have port JrEn, input, 1, jr/jalr at PC.
REQ-010 SHALL have port JrAddr, input, 32, register jump target.
REQ-011 SHALL have port Exc, input, 1, exception raised by the instruction at PC.
REQ-012 SHALL have port Eret, input, 1, eret at PC.
REQ-013 SHALL have port EPC, input, 32, return address for eret.
REQ-014 SHALL have port NPC, output, 32, next fetch address, driven into the PC register D input.
REQ-015 SHALL have port PC8, output, 32, link value PC+8.
REQ-016 SHALL have port InSlot, output, 1, instruction at PC is a delay-slot instruction.
REQ-017 SHALL have port BadSlot, output, 1, sticky: control transfer seen inside a delay slot.

Function
REQ-018 SHALL keep two states, SEQ and SLOT, plus a 32-bit register Target.
REQ-019 SHALL compute branch target = PC + 4 + (sign-extended Imm16 << 2), mod 2^32.
REQ-020 SHALL compute jump target = {PC4[31:28], Instr26, 2'b00}, with PC4 = PC + 4.
REQ-021 SHALL use JrAddr unmodified as the jr target.
REQ-022 SHALL, when more than one redirect input is high, pick the redirect source by priority JrEn > JEn > BrTaken.
REQ-023 SHALL apply per-cycle priority Exc > Eret > Stall > SLOT resolution > new redirect > sequential.
REQ-024 SHALL, on Exc: NPC = 0x0000_4180; next state SEQ; pending Target discarded; Stall ignored.
REQ-025 SHALL, on Eret (no Exc): NPC = EPC; next state SEQ; pending Target discarded; eret has no delay slot.
REQ-026 SHALL, on Stall (no Exc/Eret): NPC = PC; state, Target and BadSlot held.
REQ-027 SHALL, in SEQ with a redirect: NPC = PC4; Target <= selected target; next state SLOT.
REQ-028 SHALL, in SEQ with no redirect: NPC = PC4; state unchanged.
REQ-029 SHALL, in SLOT: NPC = Target; next state SEQ; any redirect input is ignored and sets BadSlot.
REQ-030 SHALL drive InSlot = 1 exactly while state is SLOT, combinationally from state.
REQ-031 SHALL drive NPC, PC8 and InSlot combinationally from PC, the inputs and the registered state, with zero added latency.
REQ-032 SHALL wrap all address arithmetic at 32 bits without flagging it.

Reset
REQ-033 SHALL, while Reset = 0, force state = SEQ, Target = 0 and BadSlot = 0 asynchronously.
REQ-034 SHALL give NPC = PC + 4 during reset; with PC = 0x0000_3000 this is 0x0000_3004.
REQ-035 SHALL cancel a pending SLOT redirect on reset mid-operation; after release, fetch resumes sequentially.
REQ-036 SHALL begin normal operation on the first rising Clk edge after Reset returns to 1.

Verification
REQ-037 SHALL cover sequential fetch: PC = 0x3000, no controls -> NPC = 0x3004, PC8 = 0x3008, InSlot = 0.
REQ-038 SHALL cover a taken branch: PC = 0x3010, BrTaken = 1, Imm16 = 0xFFFC -> NPC = 0x3014. Next cycle, PC = 0x3014 -> InSlot = 1, NPC = 0x3004. Cycle after -> SEQ.
REQ-039 SHALL cover redirect priority: PC = 0x3000, JrEn = 1, JrAddr = 0x3100, JEn = 1, BrTaken = 1 -> delay slot at 0x3004, then NPC = 0x3100.
REQ-040 SHALL cover Exc in a delay slot: state SLOT with Target = 0x3200, Exc = 1 -> NPC = 0x4180, InSlot = 1 that cycle; next cycle state SEQ, Target discarded.
REQ-041 SHALL cover Stall in SLOT: 3 cycles of Stall with PC = 0x3004 -> NPC = 0x3004 each cycle; on release -> NPC = Target.
REQ-042 SHALL cover async reset mid-SLOT and a branch in a delay slot: Reset low between edges -> InSlot drops immediately, NPC = PC + 4. Separately, BrTaken in SLOT -> BadSlot = 1 and stays 1 until reset.
